accuracy_tracker: RTL
=====================

Name: accuracy_tracker

Overview:
- Sits directly downstream of the DNN top, in the same clock domain.
- Consumes the one-hot prediction `a_out_alln` and the per-clock ideal-output chunks `y_out`.
- Reassembles the full ideal output vector for each block cycle and compares it with the prediction.
- Accumulates correct/total counts over a programmable window of samples and publishes the totals for training monitoring.

Parameters:
- `n_out`, 4: number of output neurons (`n[L-1]`).
- `zo`, 1: output neurons per clock, i.e. `z[L-2]/fi[L-2]`; must divide `n_out`.
- `cpc`, 6: clocks per block cycle; must equal `n_out/zo + 2`.
- `warmup`, 3: number of leading comparisons after reset/clear that are discarded (pipeline fill; set to `L`).
- `window`, 100: comparisons per accuracy window.
- `cnt_w`, `$clog2(window+1)`: counter width.

Ports:
- `clk` input 1: system clock; all state updates on its posedge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `cycle_index` input `$clog2(cpc)`: block-cycle clock counter from `cycle_block_counter`.
- `y_out` input `zo`: ideal-output chunk for neurons `zo*(cycle_index-2)` to `zo*(cycle_index-2)+zo-1`, valid when `cycle_index>1`.
- `a_out_alln` input `n_out`: one-hot prediction; stable from `cycle_index==0` to end of block.
- `clear` input 1: synchronous restart of warm-up, window and counters; outputs held.
- `hit` output 1: registered result of the most recent counted comparison.
- `hit_valid` output 1: one-clock pulse when `hit` updates.
- `correct_count` output `cnt_w`: correct comparisons in the last completed window.
- `total_count` output `cnt_w`: equals `window` once the first window completes.
- `window_done` output 1: one-clock pulse when the count outputs update.

Behaviour:
- Reset values: all outputs 0; `y_acc`, `y_shadow`, running counters and warm-up counter all 0.
- Collect: on any clk with `cycle_index>1`, write `y_out` into `y_acc[zo*(cycle_index-2) +: zo]`. Indices 0 and 1 do not write.
- Shadow: on clk with `cycle_index==0`:
  - `y_shadow <= y_acc`;
  - `y_acc <= 0`.
  - So a block missing chunks compares against zeros.
- Compare: on clk with `cycle_index==1`:
  - `match = (a_out_alln == y_shadow)`.
  - If warm-up counter < `warmup`: increment warm-up counter only; no `hit_valid`.
  - Otherwise: `hit <= match`, `hit_valid <= 1`, `run_total += 1`, `run_correct += match`.
- Latency: the prediction for block k is compared 2 clocks after block k+1 begins; `hit_valid` is high during `cycle_index==2`.
- Window completion: when the increment makes `run_total == window`, in the same clk:
  - `correct_count <= run_correct + match`;
  - `total_count <= window`;
  - `window_done <= 1`;
  - running counters reset to 0.
  - No comparison is lost at the wrap.
- Counter widths: counters never exceed `window`; widths sized per `cnt_w`, so no overflow.
- `clear`: while high, warm-up counter and running counters go to 0, `y_acc` goes to 0, and `hit_valid`/`window_done` are forced low. `hit`, `correct_count` and `total_count` hold.
- `clear` and compare coincident: `clear` wins; the comparison is discarded.
- Asynchronous reset mid-block: everything goes to the reset values at once. After release, the first block seen is partial; it falls inside warm-up as long as `warmup >= 1`.
- Prediction not one-hot (e.g. all zeros): plain equality applies, counted as miss unless `y_shadow` is identical.
- No FSM beyond phase decoding of `cycle_index`.
- Assertions:
  - `cpc == n_out/zo + 2`;
  - `n_out % zo == 0`;
  - `window >= 1`.

Decomposition:
- Package `dnn_pkg`:
  - function `calc_cpc(n0, fo0, z0)`;
  - function `clog2_min1(x)`, returning at least 1, as used for position widths when `zo==1`.
- One sub-module: `output_chunk_assembler` (params `n_out`, `zo`, `cpc`). It holds `y_acc` and `y_shadow` and exposes `y_shadow`. The compare/count logic stays in `accuracy_tracker`.

Test Plan:
- Default params (`n_out=4`, `zo=1`, `cpc=6`, `warmup=3`, `window=4`).
  - Drive `y_out` chunks 0,0,1,0 (class 2) every block and `a_out_alln=4'b0100`. Expect no `hit_valid` for the first 3 blocks, then `hit=1` pulses.
  - After 4 counted blocks, expect `window_done` with `correct_count=4`, `total_count=4`.
- Alternate predictions `4'b0100` and `4'b0001` with y fixed at class 2 -> after one window, `correct_count=2`.
- `zo=2`, `cpc=4`, `n_out=4`: chunks `2'b10` at index 2 and `2'b00` at index 3 give `y_shadow=4'b0010`. Then `a_out_alln=4'b0010` gives `hit=1`.
- Assert `clear` at `cycle_index==1` of a counted block -> no `hit_valid`. The warm-up of 3 blocks restarts, and prior `correct_count` holds.
- Assert async `reset` mid-block at `cycle_index==3` -> all outputs 0 immediately. After release, `y_acc` is partial and that block is absorbed by warm-up.
- Window boundary with the last comparison a hit -> `correct_count` includes it; the next window starts at 0 in the same clk.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared helpers for the DNN training datapath blocks.
// Sizing functions used by the output-side monitors.
package dnn_pkg;

  // Clocks per block cycle: one clock per output chunk plus two phase clocks.
  function automatic int calc_cpc(input int n0, input int fo0, input int z0);
    return (n0 * fo0) / z0 + 2;
  endfunction

  // Position width that never collapses to zero bits.
  function automatic int clog2_min1(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/output_chunk_assembler.sv
// Rebuilds the ideal output vector from per-clock chunks and
// snapshots it at the start of each block cycle.
module output_chunk_assembler
  import dnn_pkg::*;
#(
  parameter int n_out = 4,
  parameter int zo    = 1,
  parameter int cpc   = 6,
  localparam int ciw  = clog2_min1(cpc)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [ciw-1:0]   cycle_index,
  input  logic [zo-1:0]    y_out,
  output logic [n_out-1:0] y_shadow
);

  localparam int nchunk = n_out / zo;

  logic [n_out-1:0] y_acc;

  // Collect chunks during indices >= 2; hand off and restart at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_acc    <= '0;
      y_shadow <= '0;
    end else begin
      if (cycle_index == '0) begin
        y_shadow <= y_acc;
      end
      if (clear || cycle_index == '0) begin
        y_acc <= '0;
      end else begin
        for (int k = 0; k < nchunk; k++) begin
          if (cycle_index == ciw'(k + 2)) begin
            y_acc[k*zo +: zo] <= y_out;
          end
        end
      end
    end
  end

endmodule

// File: rtl/accuracy_tracker.sv
// Compares each one-hot prediction with its ideal output and
// publishes correct/total counts once per accuracy window.
module accuracy_tracker
  import dnn_pkg::*;
#(
  parameter int n_out  = 4,
  parameter int zo     = 1,
  parameter int cpc    = 6,
  parameter int warmup = 3,
  parameter int window = 100,
  parameter int cnt_w  = $clog2(window + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [clog2_min1(cpc)-1:0] cycle_index,
  input  logic [zo-1:0]        y_out,
  input  logic [n_out-1:0]     a_out_alln,
  input  logic                 clear,
  output logic                 hit,
  output logic                 hit_valid,
  output logic [cnt_w-1:0]     correct_count,
  output logic [cnt_w-1:0]     total_count,
  output logic                 window_done
);

  localparam int ciw = clog2_min1(cpc);
  localparam int ww  = clog2_min1(warmup + 1);

  if (cpc != calc_cpc(n_out, 1, zo)) begin : g_bad_cpc
    $error("accuracy_tracker: cpc must equal n_out/zo + 2");
  end
  if (n_out % zo != 0) begin : g_bad_zo
    $error("accuracy_tracker: zo must divide n_out");
  end
  if (window < 1) begin : g_bad_win
    $error("accuracy_tracker: window must be at least 1");
  end

  logic [n_out-1:0] y_shadow;
  logic [ww-1:0]    warm_cnt;
  logic [cnt_w-1:0] run_total;
  logic [cnt_w-1:0] run_correct;
  logic             match;
  logic             cmp_phase;

  output_chunk_assembler #(
    .n_out(n_out),
    .zo   (zo),
    .cpc  (cpc)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .cycle_index(cycle_index),
    .y_out      (y_out),
    .y_shadow   (y_shadow)
  );

  assign match     = (a_out_alln == y_shadow);
  assign cmp_phase = (cycle_index == ciw'(1));

  // Warm-up skip, per-sample hit, and windowed accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt      <= '0;
      run_total     <= '0;
      run_correct   <= '0;
      hit           <= 1'b0;
      hit_valid     <= 1'b0;
      correct_count <= '0;
      total_count   <= '0;
      window_done   <= 1'b0;
    end else begin
      hit_valid   <= 1'b0;
      window_done <= 1'b0;
      if (clear) begin
        warm_cnt    <= '0;
        run_total   <= '0;
        run_correct <= '0;
      end else if (cmp_phase) begin
        if (warm_cnt < ww'(warmup)) begin
          warm_cnt <= warm_cnt + 1'b1;
        end else begin
          hit       <= match;
          hit_valid <= 1'b1;
          if (run_total == cnt_w'(window - 1)) begin
            correct_count <= run_correct + cnt_w'(match);
            total_count   <= cnt_w'(window);
            window_done   <= 1'b1;
            run_total     <= '0;
            run_correct   <= '0;
          end else begin
            run_total   <= run_total + 1'b1;
            run_correct <= run_correct + cnt_w'(match);
          end
        end
      end
    end
  end

endmodule
